// File: rtl/led_matrix_scan_ctrl.sv
// Scan sequencer for a 7x5 LED matrix behind a 1-to-NUM_POS demultiplexer.
// Walks the select through every position with an optional blanking gap,
// followed by a dwell window. The data bit is driven from a double-buffered
// frame that is swapped only at frame boundaries.
module led_matrix_scan_ctrl #(
  parameter int unsigned NUM_POS = 35,
  parameter int unsigned SEL_W   = 6,
  parameter int unsigned DWELL   = 4,
  parameter int unsigned BLANK   = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic [NUM_POS-1:0] frame_data,
  input  logic               frame_valid,
  output logic               frame_ready,
  output logic [SEL_W-1:0]   sel,
  output logic               led_data,
  output logic               scan_active,
  output logic               frame_done
);

  localparam int unsigned CntMax = (DWELL > BLANK) ? DWELL : BLANK;
  localparam int unsigned CntW   = (CntMax > 1) ? $clog2(CntMax) : 1;

  localparam logic [CntW-1:0]  DwellLast = CntW'(DWELL - 1);
  localparam logic [CntW-1:0]  BlankLast = CntW'((BLANK > 0) ? BLANK - 1 : 0);
  localparam logic [SEL_W-1:0] LastPos   = SEL_W'(NUM_POS - 1);

  typedef enum logic [1:0] {StIdle, StBlank, StOn} state_e;

  // With no blanking the scan goes straight into the dwell window.
  localparam state_e StFirst = (BLANK > 0) ? StBlank : StOn;

  state_e             state_q, state_d;
  logic [SEL_W-1:0]   pos_q, pos_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [NUM_POS-1:0] active_q, active_d;
  logic [NUM_POS-1:0] pending_q, pending_d;
  logic               pending_full_q, pending_full_d;

  logic               frame_ready_q, frame_ready_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic               led_data_q, led_data_d;
  logic               scan_active_q, scan_active_d;
  logic               frame_done_q, frame_done_d;

  logic               swap;
  // Active frame reordered so bit s is what select value s must show.
  logic [(1<<SEL_W)-1:0] scan_order;

  // Next-state: scan sequencing, frame buffer swap/accept, registered outputs.
  always_comb begin
    state_d        = state_q;
    pos_d          = pos_q;
    cnt_d          = cnt_q;
    active_d       = active_q;
    pending_d      = pending_q;
    pending_full_d = pending_full_q;
    frame_done_d   = 1'b0;
    swap           = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (enable) begin
          state_d = StFirst;
          pos_d   = '0;
          cnt_d   = '0;
          swap    = pending_full_q;
        end
      end
      StBlank: begin
        if (!enable) begin
          state_d = StIdle;
          pos_d   = '0;
          cnt_d   = '0;
        end else if (cnt_q == BlankLast) begin
          state_d = StOn;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StOn: begin
        if (!enable) begin
          state_d = StIdle;
          pos_d   = '0;
          cnt_d   = '0;
        end else if (cnt_q == DwellLast) begin
          state_d = StFirst;
          cnt_d   = '0;
          if (pos_q == LastPos) begin
            pos_d        = '0;
            frame_done_d = 1'b1;
            swap         = pending_full_q;
          end else begin
            pos_d = pos_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
        pos_d   = '0;
        cnt_d   = '0;
      end
    endcase

    // Swap reads the old pending contents; a frame accepted on the same edge
    // refills pending.
    if (swap) begin
      active_d       = pending_q;
      pending_full_d = 1'b0;
    end
    if (frame_valid && frame_ready_q) begin
      pending_d      = frame_data;
      pending_full_d = 1'b1;
    end

    scan_order = '0;
    for (int unsigned i = 0; i < NUM_POS; i++) begin
      scan_order[i] = active_d[NUM_POS-1-i];
    end

    frame_ready_d = !pending_full_d;
    scan_active_d = (state_d != StIdle);
    sel_d         = (state_d == StIdle) ? '0 : pos_d;
    led_data_d    = (state_d == StOn) && scan_order[pos_d];
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= StIdle;
      pos_q          <= '0;
      cnt_q          <= '0;
      active_q       <= '0;
      pending_q      <= '0;
      pending_full_q <= 1'b0;
      frame_ready_q  <= 1'b1;
      sel_q          <= '0;
      led_data_q     <= 1'b0;
      scan_active_q  <= 1'b0;
      frame_done_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      pos_q          <= pos_d;
      cnt_q          <= cnt_d;
      active_q       <= active_d;
      pending_q      <= pending_d;
      pending_full_q <= pending_full_d;
      frame_ready_q  <= frame_ready_d;
      sel_q          <= sel_d;
      led_data_q     <= led_data_d;
      scan_active_q  <= scan_active_d;
      frame_done_q   <= frame_done_d;
    end
  end

  assign frame_ready = frame_ready_q;
  assign sel         = sel_q;
  assign led_data    = led_data_q;
  assign scan_active = scan_active_q;
  assign frame_done  = frame_done_q;

endmodule

// File: tb/tb_led_matrix_scan_ctrl.sv
// Directed bench for led_matrix_scan_ctrl: a table of timed vectors against
// the default-parameter instance, then a per-cycle sequence against an
// instance with no blanking and a single-cycle dwell.
module tb_led_matrix_scan_ctrl;

  localparam logic [34:0] FrA = 35'h4_0000_0001;  // pos 0 and pos 34 lit
  localparam logic [34:0] FrC = 35'h2_0000_0000;  // pos 1 lit
  localparam logic [34:0] FrD = 35'h1_0000_0000;  // pos 2 lit

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // Default instance
  logic        rst_n = 1'b0, enable = 1'b0, frame_valid = 1'b0;
  logic [34:0] frame_data = '0;
  logic        frame_ready, led_data, scan_active, frame_done;
  logic [5:0]  sel;

  // Fast instance
  logic        rst_n_f = 1'b0, enable_f = 1'b0, frame_valid_f = 1'b0;
  logic [34:0] frame_data_f = '0;
  logic        frame_ready_f, led_data_f, scan_active_f, frame_done_f;
  logic [5:0]  sel_f;

  led_matrix_scan_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .frame_data  (frame_data),
    .frame_valid (frame_valid),
    .frame_ready (frame_ready),
    .sel         (sel),
    .led_data    (led_data),
    .scan_active (scan_active),
    .frame_done  (frame_done)
  );

  led_matrix_scan_ctrl #(
    .NUM_POS (35),
    .SEL_W   (6),
    .DWELL   (1),
    .BLANK   (0)
  ) dut_fast (
    .clk         (clk),
    .rst_n       (rst_n_f),
    .enable      (enable_f),
    .frame_data  (frame_data_f),
    .frame_valid (frame_valid_f),
    .frame_ready (frame_ready_f),
    .sel         (sel_f),
    .led_data    (led_data_f),
    .scan_active (scan_active_f),
    .frame_done  (frame_done_f)
  );

  typedef struct {
    string       name;
    logic        rst_n;
    logic        en;
    logic        fv;
    logic [34:0] fd;
    int          ncyc;
    logic [5:0]  e_sel;
    logic        e_led;
    logic        e_rdy;
    logic        e_act;
    logic        e_done;
  } vec_t;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name,
                       input logic [5:0] a_sel, input logic a_led, input logic a_rdy,
                       input logic a_act, input logic a_done,
                       input logic [5:0] e_sel, input logic e_led, input logic e_rdy,
                       input logic e_act, input logic e_done);
    n_vec++;
    if (a_sel !== e_sel || a_led !== e_led || a_rdy !== e_rdy ||
        a_act !== e_act || a_done !== e_done) begin
      n_err++;
      $display("FAIL %s: got sel=%0d led=%b rdy=%b act=%b done=%b, want sel=%0d led=%b rdy=%b act=%b done=%b",
               name, a_sel, a_led, a_rdy, a_act, a_done, e_sel, e_led, e_rdy, e_act, e_done);
    end
  endtask

  vec_t vt[36];

  initial begin
    // Each row: drive inputs, let ncyc edges pass, sample 1 time unit later.
    // E = edge where enable is first sampled; after E+5p is BLANK of pos p,
    // E+5p+1..4 is ON of pos p, frame_done high after E+175.
    vt[0]  = '{"reset",        0, 0, 0, '0,    2,  0, 0, 1, 0, 0};
    vt[1]  = '{"load_a",       1, 0, 1, FrA,   1,  0, 0, 0, 0, 0};
    vt[2]  = '{"enable",       1, 1, 0, '0,    1,  0, 0, 1, 1, 0};
    vt[3]  = '{"p0_on1",       1, 1, 0, '0,    1,  0, 1, 1, 1, 0};
    vt[4]  = '{"p0_on4",       1, 1, 0, '0,    3,  0, 1, 1, 1, 0};
    vt[5]  = '{"p1_blank",     1, 1, 0, '0,    1,  1, 0, 1, 1, 0};
    vt[6]  = '{"p1_on2",       1, 1, 0, '0,    2,  1, 0, 1, 1, 0};
    vt[7]  = '{"p33_on2",      1, 1, 0, '0,  160, 33, 0, 1, 1, 0};
    vt[8]  = '{"p34_blank",    1, 1, 0, '0,    3, 34, 0, 1, 1, 0};
    vt[9]  = '{"p34_on1",      1, 1, 0, '0,    1, 34, 1, 1, 1, 0};
    vt[10] = '{"p34_on4",      1, 1, 0, '0,    3, 34, 1, 1, 1, 0};
    vt[11] = '{"frame_done",   1, 1, 0, '0,    1,  0, 0, 1, 1, 1};
    vt[12] = '{"wrap_on1",     1, 1, 0, '0,    1,  0, 1, 1, 1, 0};
    vt[13] = '{"p17_on2",      1, 1, 0, '0,   86, 17, 0, 1, 1, 0};
    vt[14] = '{"disable",      1, 0, 0, '0,    1,  0, 0, 1, 0, 0};
    vt[15] = '{"idle_hold",    1, 0, 0, '0,  200,  0, 0, 1, 0, 0};
    vt[16] = '{"reenable",     1, 1, 0, '0,    1,  0, 0, 1, 1, 0};
    vt[17] = '{"re_p0_on1",    1, 1, 0, '0,    1,  0, 1, 1, 1, 0};
    vt[18] = '{"re_done",      1, 1, 0, '0,  174,  0, 0, 1, 1, 1};
    vt[19] = '{"accept_c",     1, 1, 1, FrC,   1,  0, 1, 0, 1, 0};
    vt[20] = '{"hold_d",       1, 1, 1, FrD,   1,  0, 1, 0, 1, 0};
    vt[21] = '{"bp_p34_on4",   1, 1, 1, FrD, 172, 34, 1, 0, 1, 0};
    vt[22] = '{"swap_c",       1, 1, 1, FrD,   1,  0, 0, 1, 1, 1};
    vt[23] = '{"accept_d",     1, 1, 1, FrD,   1,  0, 0, 0, 1, 0};
    vt[24] = '{"c_p1_on1",     1, 1, 0, '0,    5,  1, 1, 0, 1, 0};
    vt[25] = '{"c_p2_on1",     1, 1, 0, '0,    5,  2, 0, 0, 1, 0};
    vt[26] = '{"swap_d",       1, 1, 0, '0,  164,  0, 0, 1, 1, 1};
    vt[27] = '{"d_p1_on1",     1, 1, 0, '0,    6,  1, 0, 1, 1, 0};
    vt[28] = '{"d_p2_on1",     1, 1, 0, '0,    5,  2, 1, 1, 1, 0};
    vt[29] = '{"load_pend",    1, 1, 1, FrA,   1,  2, 1, 0, 1, 0};
    vt[30] = '{"p20_on1",      1, 1, 0, '0,   89, 20, 0, 0, 1, 0};
    vt[31] = '{"mid_reset",    0, 1, 0, '0,    1,  0, 0, 1, 0, 0};
    vt[32] = '{"post_rst_en",  1, 1, 0, '0,    1,  0, 0, 1, 1, 0};
    vt[33] = '{"post_p0_on1",  1, 1, 0, '0,    1,  0, 0, 1, 1, 0};
    vt[34] = '{"post_p34_on1", 1, 1, 0, '0,  170, 34, 0, 1, 1, 0};
    vt[35] = '{"post_done",    1, 1, 0, '0,    4,  0, 0, 1, 1, 1};

    for (int i = 0; i < 36; i++) begin
      rst_n       = vt[i].rst_n;
      enable      = vt[i].en;
      frame_valid = vt[i].fv;
      frame_data  = vt[i].fd;
      repeat (vt[i].ncyc) @(posedge clk);
      #1;
      check(vt[i].name, sel, led_data, frame_ready, scan_active, frame_done,
            vt[i].e_sel, vt[i].e_led, vt[i].e_rdy, vt[i].e_act, vt[i].e_done);
    end

    // No-blank, single-cycle dwell: sel steps every cycle, frame_done every 35.
    rst_n_f       = 1'b1;
    frame_valid_f = 1'b1;
    frame_data_f  = FrA;
    @(posedge clk);
    #1;
    frame_valid_f = 1'b0;
    enable_f      = 1'b1;
    @(posedge clk);
    #1;
    for (int k = 0; k < 80; k++) begin
      automatic int p = k % 35;
      automatic logic e_led = (p == 0) || (p == 34);
      automatic logic e_done = (k > 0) && (p == 0);
      check($sformatf("fast_k%0d", k), sel_f, led_data_f, frame_ready_f, scan_active_f,
            frame_done_f, 6'(p), e_led, 1'b1, 1'b1, e_done);
      @(posedge clk);
      #1;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
